// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Counter width for n digits; never narrower than one bit so N=1 still elaborates.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_addsub_digit_add.sv
// DIGIT-wide ripple adder with carry-in and carry-out.
module digit_add #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  logic [DIGIT:0] c;

  always_comb begin
    c[0] = cin;
    sum  = '0;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[DIGIT];
  end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: LSB-first, DIGIT bits per clock through a registered carry.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
    $error("serial_addsub: DIGIT must be >= 1 and divide WIDTH");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] work;
  logic             cy;
  logic             sa;
  logic             sb;

  logic [WIDTH-1:0] b_eff;
  logic [DIGIT-1:0] d_sum;
  logic             d_cout;
  logic [WIDTH-1:0] work_next;

  assign b_eff = sub ? ~b : b;

  digit_add #(.DIGIT(DIGIT)) u_digit_add (
    .a    (op_a[DIGIT-1:0]),
    .b    (op_b[DIGIT-1:0]),
    .cin  (cy),
    .sum  (d_sum),
    .cout (d_cout)
  );

  // New digit enters at the MSB end so the finished word ends up LSB-aligned.
  assign work_next = (work >> DIGIT) | (WIDTH'(d_sum) << (WIDTH - DIGIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      work  <= '0;
      cy    <= 1'b0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= a;
            op_b  <= b_eff;
            cy    <= sub;
            cnt   <= '0;
            work  <= '0;
            sa    <= a[WIDTH-1];
            sb    <= b_eff[WIDTH-1];
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          work <= work_next;
          cy   <= d_cout;
          op_a <= op_a >> DIGIT;
          op_b <= op_b >> DIGIT;
          cnt  <= cnt + CW'(1);
          // Results are only touched here, so they hold across later starts.
          if (cnt == LAST) begin
            sum   <= work_next;
            carry <= d_cout;
            ovf   <= (sa == sb) && (work_next[WIDTH-1] != sa);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: one DIGIT=1 and one DIGIT=4 instance on a shared clock/reset.
module tb_serial_addsub;

  localparam int W  = 8;
  localparam int N1 = 8;
  localparam int N4 = 2;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         start1 = 1'b0, sub1 = 1'b0;
  logic [W-1:0] a1 = '0, b1 = '0;
  logic         busy1, done1, carry1, ovf1;
  logic [W-1:0] sum1;

  logic         start4 = 1'b0, sub4 = 1'b0;
  logic [W-1:0] a4 = '0, b4 = '0;
  logic         busy4, done4, carry4, ovf4;
  logic [W-1:0] sum4;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t q1[$];
  exp_t q4[$];

  serial_addsub #(.WIDTH(W), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1), .ovf(ovf1)
  );

  serial_addsub #(.WIDTH(W), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .carry(carry4), .ovf(ovf4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation on the chosen instance and push its hand-computed result.
  task automatic applyStimulus(input bit use4, input logic [W-1:0] ia, input logic [W-1:0] ib,
                               input logic isub, input logic [W-1:0] es, input logic ec,
                               input logic eo);
    int guard = 0;
    exp_t e;
    @(negedge clk);
    while ((use4 ? busy4 : busy1) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: busy stuck at 1, expected 0");
      return;
    end
    if (use4) begin
      a4 = ia; b4 = ib; sub4 = isub; start4 = 1'b1;
    end else begin
      a1 = ia; b1 = ib; sub1 = isub; start1 = 1'b1;
    end
    @(posedge clk);
    #1;
    e.sum   = es;
    e.carry = ec;
    e.ovf   = eo;
    e.cyc   = cyc + (use4 ? N4 : N1);
    if (use4) begin
      q4.push_back(e);
      start4 = 1'b0;
    end else begin
      q1.push_back(e);
      start1 = 1'b0;
    end
  endtask

  // Monitor: every done pulse is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL dut1_unexpected_done: got done=1 expected no pulse");
      end else begin
        e = q1.pop_front();
        checkOutput("dut1_sum",     32'(sum1),   32'(e.sum));
        checkOutput("dut1_carry",   32'(carry1), 32'(e.carry));
        checkOutput("dut1_ovf",     32'(ovf1),   32'(e.ovf));
        checkOutput("dut1_latency", 32'(cyc),    32'(e.cyc));
      end
    end
    if (done4) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL dut4_unexpected_done: got done=1 expected no pulse");
      end else begin
        e = q4.pop_front();
        checkOutput("dut4_sum",     32'(sum4),   32'(e.sum));
        checkOutput("dut4_carry",   32'(carry4), 32'(e.carry));
        checkOutput("dut4_ovf",     32'(ovf4),   32'(e.ovf));
        checkOutput("dut4_latency", 32'(cyc),    32'(e.cyc));
      end
    end
  end

  task automatic waitIdle(input int limit);
    int n = 0;
    while ((q1.size() != 0 || q4.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (q1.size() != 0 || q4.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d/%0d pending expected 0",
               q1.size(), q4.size());
      q1.delete();
      q4.delete();
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_busy",  32'(busy1),  32'(0));
    checkOutput("reset_done",  32'(done1),  32'(0));
    checkOutput("reset_sum",   32'(sum1),   32'(0));
    checkOutput("reset_carry", 32'(carry1), 32'(0));
    checkOutput("reset_ovf",   32'(ovf1),   32'(0));
    checkOutput("reset_busy4", 32'(busy4),  32'(0));

    // 0x5A + 0x3C, then a stray start while busy that must be ignored.
    applyStimulus(1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    checkOutput("busy_after_accept", 32'(busy1), 32'(1));
    repeat (2) @(negedge clk);
    a1 = 8'h11; b1 = 8'h22; sub1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    a1 = 8'h00; b1 = 8'h00; sub1 = 1'b0;
    waitIdle(50);
    repeat (4) @(negedge clk);
    checkOutput("hold_sum",   32'(sum1),   32'(8'h96));
    checkOutput("hold_ovf",   32'(ovf1),   32'(1));
    checkOutput("hold_busy",  32'(busy1),  32'(0));

    // 0x10 - 0x20
    applyStimulus(1'b0, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    waitIdle(50);

    // 0xFF + 0x01 with a back-to-back 0x01 + 0x01 launched in the done cycle.
    applyStimulus(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
    waitIdle(50);

    // DIGIT=4: 0x80 - 0x01, busy for exactly two cycles.
    applyStimulus(1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    checkOutput("dut4_busy_c1", 32'(busy4), 32'(1));
    @(posedge clk); #1;
    checkOutput("dut4_busy_c2", 32'(busy4), 32'(1));
    @(posedge clk); #1;
    checkOutput("dut4_busy_end", 32'(busy4), 32'(0));
    waitIdle(20);

    // Abort at digit 3 of 8 with asynchronous reset.
    @(negedge clk);
    a1 = 8'h5A; b1 = 8'h3C; sub1 = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_busy",  32'(busy1),  32'(0));
    checkOutput("abort_done",  32'(done1),  32'(0));
    checkOutput("abort_sum",   32'(sum1),   32'(0));
    checkOutput("abort_carry", 32'(carry1), 32'(0));
    checkOutput("abort_ovf",   32'(ovf1),   32'(0));
    checkOutput("abort_sum4",  32'(sum4),   32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    applyStimulus(1'b0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
    waitIdle(50);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation time exceeded");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised digit-serial adder/subtractor, the sequential successor to our single-bit combinational half adder. It accepts two WIDTH-bit operands on a start pulse and processes DIGIT bits per clock, LSB first, through a registered carry. After completion it holds sum, carry-out and signed overflow stable. It sits behind the tile's input pins, trading area for latency, and feeds the output pins.

## Interface
- WIDTH, default 8: operand and result width in bits.
- DIGIT, default 1: bits processed per cycle. Must divide WIDTH. N = WIDTH/DIGIT.
- clk  input  1  Single clock, rising edge.
- rst  input  1  Asynchronous, active-high reset.
- start  input  1  Request. Sampled only when busy=0.
- sub  input  1  0 = a+b, 1 = a−b. Sampled with start.
- a  input  WIDTH  Operand A. Sampled with start.
- b  input  WIDTH  Operand B. Sampled with start.
- busy  output  1  High while digits are being processed.
- done  output  1  One-cycle pulse when the result registers update.
- sum  output  WIDTH  Result, low WIDTH bits.
- carry  output  1  Carry-out. For subtract, 1 = no borrow.
- ovf  output  1  Two's-complement signed overflow.

## Operation
- States: IDLE and RUN.
- IDLE with start=1:
  - Latch a into opA.
  - Latch b into opB, or ~b when sub=1.
  - Set the carry register to sub.
  - Clear the digit counter and the work shift register.
  - Store sa = a[WIDTH-1] and sb = opB[WIDTH-1].
  - Go to RUN with busy=1.
- RUN, each edge:
  - Add {carry, opA[DIGIT-1:0], opB[DIGIT-1:0]}. The low DIGIT bits enter the work register at the MSB end, shifting right by DIGIT. The DIGIT+1 bit becomes the new carry.
  - Shift opA and opB right by DIGIT.
  - Increment the counter.
- Final RUN edge (counter = N−1):
  - Load sum from the completed work value.
  - Load carry with the final carry.
  - Load ovf = (sa == sb) && (sum_msb != sa).
  - Pulse done=1, set busy=0, return to IDLE.
- Result outputs change only on the final edge. They hold until the next completion, not merely the next start.
- Arithmetic is modulo 2^WIDTH. Subtract is a + ~b + 1.

## Timing
- Reset values: state IDLE, busy=0, done=0, sum=0, carry=0, ovf=0. Counter and internal registers are 0.
- Latency: a start accepted at edge k gives done=1 during the cycle after edge k+N.
  - busy is high for exactly N cycles.
  - DIGIT=WIDTH gives 1-cycle latency.
- start while busy=1 is ignored. No queuing, and no change to operands in flight.
- start in the done cycle is accepted (busy=0 there). Back-to-back throughput is one operation per N+1 cycles.
- start held high continuously relaunches on every busy=0 cycle.
- Reset asserted mid-operation:
  - Aborts immediately and asynchronously.
  - done is not pulsed.
  - All outputs return to reset values.
  - The first start after deassertion behaves normally.
- The a, b and sub inputs are don't-care except in the start-accept cycle.

## Structure
- Shared package serial_addsub_pkg:
  - state enum type (IDLE, RUN);
  - counter width constant, clog2 of N, minimum 1.
- Elaboration-time check: WIDTH % DIGIT == 0 and DIGIT ≥ 1.
- One combinational sub-module, digit_add: a DIGIT-wide ripple adder with carry-in and carry-out, instantiated once.
- Top level holds the FSM, counter, shift registers and result registers.

## Test plan
- WIDTH=8, DIGIT=1: start with a=0x5A, b=0x3C, sub=0.
  - Required: done in the 8th cycle after the accept edge.
  - sum=0x96, carry=0, ovf=1.
- WIDTH=8, DIGIT=1: a=0x10, b=0x20, sub=1.
  - Required: sum=0xF0, carry=0, ovf=0.
- WIDTH=8, DIGIT=4: a=0x80, b=0x01, sub=1.
  - Required: busy for 2 cycles.
  - sum=0x7F, carry=1, ovf=1.
- WIDTH=8, DIGIT=1: a=0xFF, b=0x01, sub=0.
  - Required: sum=0x00, carry=1, ovf=0.
  - A second start in the done cycle (0x01+0x01) completes N+1 cycles later with sum=0x02.
- Start pulsed again while busy with different operands.
  - Required: ignored; the first result is unchanged.
- Reset asserted at digit 3 of 8.
  - Required: busy, done, sum, carry and ovf are all 0 immediately, with no done pulse.
  - A following 0x01+0x02 gives sum=0x03.
